// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready request/response handshake,
// byte-enabled writes, write protect, range errors and a sequential clear.
module data_memory_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                wr_protect,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BW = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE, RD_WAIT, RESP, CLEAR
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     clr_q, clr_d;

  logic              mem_we;
  logic [AW-1:0]     we_idx;
  logic [DATA_W-1:0] we_data;
  logic [BW-1:0]     we_be;

  logic [ADDR_W-1:0] ra;
  logic              ra_ok;
  logic              wa_ok;
  logic [DATA_W-1:0] ra_word;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Latency-1 reads sample the array on the acceptance edge itself.
  always_comb begin
    ra      = (state_q == IDLE) ? req_addr : addr_q;
    ra_ok   = in_rng(ra);
    wa_ok   = in_rng(req_addr);
    ra_word = ra_ok ? mem[ra[AW-1:0]] : '0;
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    mem_we  = 1'b0;
    we_idx  = req_addr[AW-1:0];
    we_data = req_wdata;
    we_be   = req_be;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          clr_d   = '0;
        end else if (ready_q && req_valid) begin
          ready_d = 1'b0;
          addr_d  = req_addr;
          if (req_write) begin
            mem_we  = !wr_protect && wa_ok;
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = '0;
            err_d   = wr_protect || !wa_ok;
          end else if (RD_LATENCY == 1) begin
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = ra_word;
            err_d   = !ra_ok;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = 3'(RD_LATENCY - 1);
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          valid_d = 1'b1;
          rdata_d = ra_word;
          err_d   = !ra_ok;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      CLEAR: begin
        mem_we  = 1'b1;
        we_idx  = clr_q;
        we_data = '0;
        we_be   = '1;
        clr_d   = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  // Storage array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (we_be[i]) mem[we_idx][8*i +: 8] <= we_data[8*i +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign clear_busy = busy_q;
  assign rsp_valid  = valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (DEPTH=200, RD_LATENCY=2).
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        wr_protect;
  logic        clear_start;
  logic        clear_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  data_memory_ctrl #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .wr_protect(wr_protect),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic [31:0] rd,
                        output logic er);
    wait_ready();
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  int          lat;
  int          n;
  int          nz;
  logic [31:0] rd;
  logic        er;
  logic        seen;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; wr_protect = 1'b0;
    clear_start = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // seed nonzero words so the clear has something to wipe
    do_req(1'b1, 8'd0, 32'hAAAAAAAA, 4'hF, lat, rd, er);
    do_req(1'b1, 8'd199, 32'h12345678, 4'hF, lat, rd, er);
    do_req(1'b0, 8'd199, 32'h0, 4'h0, lat, rd, er);
    chk("seed_rd", rd, 32'h12345678);

    wait_ready();
    clear_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
    @(posedge clk); #1;
    clear_start = 1'b0;
    req_valid = 1'b0;
    chk("clr_ready_lo", 32'(req_ready), 32'd0);
    n = 0;
    seen = 1'b0;
    while (clear_busy && n < 1000) begin
      n++;
      seen |= rsp_valid;
      @(posedge clk); #1;
    end
    chk("clr_cycles", 32'(n), 32'd200);
    chk("clr_no_rsp", 32'(seen | rsp_valid), 32'd0);
    chk("clr_ready", 32'(req_ready), 32'd1);
    nz = 0;
    for (int i = 0; i < 200; i++) begin
      do_req(1'b0, 8'(i), 32'h0, 4'h0, lat, rd, er);
      if (rd !== 32'h0 || er !== 1'b0) nz++;
    end
    chk("clr_all_zero", 32'(nz), 32'd0);

    do_req(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, lat, rd, er);
    chk("wr_lat", 32'(lat), 32'd1);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    do_req(1'b0, 8'd5, 32'h0, 4'h0, lat, rd, er);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    do_req(1'b1, 8'd5, 32'h11223344, 4'b0101, lat, rd, er);
    do_req(1'b0, 8'd5, 32'h0, 4'h0, lat, rd, er);
    chk("be_merge", rd, 32'hDE22BE44);

    do_req(1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, lat, rd, er);
    chk("be0_err", 32'(er), 32'd0);
    do_req(1'b0, 8'd5, 32'h0, 4'h0, lat, rd, er);
    chk("be0_nochg", rd, 32'hDE22BE44);

    wr_protect = 1'b1;
    do_req(1'b1, 8'd7, 32'h55, 4'hF, lat, rd, er);
    chk("wp_err", 32'(er), 32'd1);
    wr_protect = 1'b0;
    do_req(1'b0, 8'd7, 32'h0, 4'h0, lat, rd, er);
    chk("wp_rd", rd, 32'd0);
    chk("wp_rd_err", 32'(er), 32'd0);

    do_req(1'b0, 8'd210, 32'h0, 4'h0, lat, rd, er);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    do_req(1'b1, 8'd200, 32'hCAFEF00D, 4'hF, lat, rd, er);
    chk("oor_wr_err", 32'(er), 32'd1);
    do_req(1'b0, 8'd199, 32'h0, 4'h0, lat, rd, er);
    chk("oor_nochg", rd, 32'd0);
    do_req(1'b0, 8'd0, 32'h0, 4'h0, lat, rd, er);
    chk("oor_nochg0", rd, 32'd0);

    // response back-pressure
    rsp_ready = 1'b0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44 ||
          req_ready !== 1'b0) nz++;
      @(posedge clk); #1;
    end
    chk("stall_stable", 32'(nz), 32'd0);
    chk("stall_hold", rsp_rdata, 32'hDE22BE44);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_rel_valid", 32'(rsp_valid), 32'd0);
    chk("stall_rel_ready", 32'(req_ready), 32'd1);

    // reset while a read is waiting
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rdw_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rdw_rst_ready", 32'(req_ready), 32'd0);
    chk("rdw_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rdw_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= rsp_valid;
      @(posedge clk); #1;
    end
    chk("rdw_no_rsp", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised single-port data memory with a valid/ready request/response handshake; next generation of the core's data memory.
- Adds configurable width, depth and read latency, byte-enabled writes, and a write-protect input.
- Adds out-of-range error reporting and a sequential whole-array clear engine, replacing the old per-address reset clear.
- Sits between the processor's load/store datapath and the storage array; exactly one request outstanding at a time.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 8, request address width in words.
- DEPTH, 256, number of implemented words; must be at most 2^ADDR_W.
- RD_LATENCY, 2, cycles from read acceptance to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits 8i+7..8i.
- wr_protect  in  1  1 = writes are blocked (the old mode=1 behaviour).
- clear_start  in  1  request a zero-fill of the whole array.
- clear_busy  out  1  clear in progress.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  request failed (out of range or write-protected).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; req_ready=0 while reset is asserted.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_busy=0; latency counter=0.
  - Array contents are not reset.
  - req_ready=1 from the first edge after reset is released.
- States are IDLE, RD_WAIT, RESP and CLEAR. req_ready=1 only in IDLE.
- IDLE:
  - If clear_start=1: go to CLEAR. clear_start has priority over a same-cycle req_valid, and that request is not accepted.
  - Else if req_valid=1: accept. Capture addr, write and wdata.
  - Accepted write: on the same edge, update each byte whose req_be bit is 1, only when wr_protect=0 and addr<DEPTH. Go to RESP with rsp_rdata=0 and rsp_err=(wr_protect | addr>=DEPTH). rsp_valid rises 1 cycle after acceptance.
  - req_be=0 with a legal address is a legal no-op write and returns rsp_err=0.
  - Accepted read: go to RD_WAIT with counter=RD_LATENCY-1. If RD_LATENCY=1, go directly to RESP.
- RD_WAIT:
  - Counter decrements each cycle. When it reaches 0, go to RESP.
  - Load rsp_rdata=mem[addr], or 0 with rsp_err=1 if addr>=DEPTH.
  - rsp_valid rises exactly RD_LATENCY cycles after the acceptance edge.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid falls, and req_ready rises on that same edge; there is no same-cycle bypass.
  - rsp_rdata and rsp_err hold their last values until the next response loads.
- CLEAR:
  - clear_busy=1. Writes 0 to one word per cycle, addresses 0..DEPTH-1 in order; this takes DEPTH cycles.
  - Then return to IDLE and drop clear_busy.
  - clear_start is ignored outside IDLE, and wr_protect does not block a clear.
- Reads return the array value as of the acceptance edge. No concurrent write is possible, so there is no hazard.
- Address compare is unsigned at ADDR_W bits. When DEPTH=2^ADDR_W, no out-of-range error is possible.
- Reset mid-operation: a pending response is discarded and a clear is aborted, leaving the array partially cleared. Nothing is retained after rst rises.
- Input request signals are don't-care while req_ready=0.

Test Plan:
- Reset, then write addr=5 wdata=0xDEADBEEF be=4'hF, then read addr=5 with RD_LATENCY=2 -> write response 1 cycle later with err=0; read rsp_valid exactly 2 cycles after acceptance with rsp_rdata=0xDEADBEEF.
- Write addr=5 wdata=0x11223344 be=4'b0101 over 0xDEADBEEF, then read -> rsp_rdata=0xDE22BE44.
- wr_protect=1, write addr=7 data=0x55, then read addr=7 -> write response err=1; read returns the prior value (0 after a clear).
- DEPTH=200: read addr=210 and write addr=200 -> both responses err=1, read rsp_rdata=0, array unchanged.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles and req_ready=0; release -> req_ready=1 on the next cycle.
- clear_start and req_valid asserted together -> clear_busy high for exactly DEPTH cycles, request not accepted, all words read back 0.
- Assert rst during RD_WAIT -> rsp_valid never rises, and req_ready=1 one edge after release.
